// File: rtl/readback_pkg.sv
// Shared constants for the counter-readback byte link.
// Both the transmitter and the receive-side parser import this package.
package readback_pkg;

  localparam logic [1:0] LO      = 2'b00;
  localparam logic [1:0] HDR     = 2'b01;
  localparam logic [1:0] HI      = 2'b10;
  localparam logic [1:0] HI_LAST = 2'b11;

  localparam logic [15:0] MARKER   = 16'h55AA;
  localparam logic [7:0]  HDR_DATA = 8'hFF;

  localparam int RB_NWORDS = 13;

  localparam logic [3:0] W_MARK     = 4'd0;
  localparam logic [3:0] W_FRAME_LO = 4'd1;
  localparam logic [3:0] W_FRAME_HI = 4'd2;
  localparam logic [3:0] W_EVENT_LO = 4'd3;
  localparam logic [3:0] W_EVENT_HI = 4'd4;
  localparam logic [3:0] W_READ1_LO = 4'd5;
  localparam logic [3:0] W_READ1_HI = 4'd6;
  localparam logic [3:0] W_READ2_LO = 4'd7;
  localparam logic [3:0] W_READ2_HI = 4'd8;
  localparam logic [3:0] W_ERR1     = 4'd9;
  localparam logic [3:0] W_ERR2     = 4'd10;
  localparam logic [3:0] W_HIST     = 4'd11;
  localparam logic [3:0] W_TRAIL    = 4'd12;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_MARKER  = 3'd1,
    ERR_FLAG    = 3'd2,
    ERR_RSVD    = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_RESYNC  = 3'd5
  } err_code_e;

endpackage

// File: rtl/rb_word_assembler.sv
// Pairs hi/lo bytes into 16-bit words and checks each byte's flag against
// the position the parser says it is at.
module rb_word_assembler
  import readback_pkg::*;
(
  input  logic        clk16,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [9:0]  bytin,
  input  logic        in_hi,
  input  logic        in_lo,
  input  logic        last_word,
  output logic        word_strobe,
  output logic [1:0]  hi_flag,
  output logic [15:0] word,
  output logic        flag_err
);

  logic [7:0] hi_byte_reg;
  logic [1:0] hi_flag_reg;
  logic [1:0] hi_expect;

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte_reg <= 8'h00;
      hi_flag_reg <= LO;
    end else if (byte_valid && in_hi) begin
      hi_byte_reg <= bytin[7:0];
      hi_flag_reg <= bytin[9:8];
    end
  end

  // Groups end on w8 and w12; those hi bytes must carry the last-of-group flag.
  assign hi_expect   = last_word ? HI_LAST : HI;
  assign word_strobe = byte_valid && in_lo;
  assign word        = {hi_byte_reg, bytin[7:0]};
  assign hi_flag     = hi_flag_reg;
  assign flag_err    = byte_valid &&
                       ((in_hi && (bytin[9:8] != hi_expect)) ||
                        (in_lo && (bytin[9:8] != LO)));

endmodule

// File: rtl/readback_frame_parser.sv
// Receive side of the counter-readback link: rebuilds a 28-byte record, validates
// framing, publishes good records atomically and counts good and aborted records.
module readback_frame_parser
  import readback_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int TO_WIDTH = 7
) (
  input  logic        clk16,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [9:0]  bytin,
  output logic [4:0]  crate,
  output logic [23:0] framecount,
  output logic [23:0] eventcount,
  output logic [23:0] read1count,
  output logic [23:0] read2count,
  output logic [7:0]  t1_err_c_cnt,
  output logic [7:0]  t1_err_d_cnt,
  output logic [7:0]  t2_err_c_cnt,
  output logic [7:0]  t2_err_d_cnt,
  output logic [10:0] hist_wcount,
  output logic        rec_valid,
  output logic        rec_err,
  output logic [2:0]  err_code,
  output logic [15:0] rec_count,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CRATE, ST_HI, ST_LO} state_e;

  state_e        state_reg, state_next;
  logic [3:0]    widx_reg, widx_next;
  logic [TO_WIDTH-1:0] to_cnt_reg, to_cnt_next;

  logic          abort, publish, hdr_accept, crate_load, word_load;
  err_code_e     abort_code;
  logic          is_hdr, rsvd_err, last_word, grp_end;

  logic          word_strobe, flag_err;
  logic [1:0]    hi_flag;
  logic [15:0]   word;

  logic [4:0]    sh_crate_reg;
  logic [23:0]   sh_frame_reg, sh_event_reg, sh_read1_reg, sh_read2_reg;
  logic [7:0]    sh_t1c_reg, sh_t1d_reg, sh_t2c_reg, sh_t2d_reg;
  logic [10:0]   sh_hist_reg;

  assign last_word = (widx_reg == W_READ2_HI) || (widx_reg == W_TRAIL);
  assign busy      = (state_reg != ST_IDLE);

  rb_word_assembler u_asm (
    .clk16       (clk16),
    .rst_n       (rst_n),
    .byte_valid  (byte_valid),
    .bytin       (bytin),
    .in_hi       (state_reg == ST_HI),
    .in_lo       (state_reg == ST_LO),
    .last_word   (last_word),
    .word_strobe (word_strobe),
    .hi_flag     (hi_flag),
    .word        (word),
    .flag_err    (flag_err)
  );

  always_comb begin
    is_hdr   = (bytin == {HDR, HDR_DATA});
    grp_end  = (hi_flag == HI_LAST);
    rsvd_err = 1'b0;
    case (widx_reg)
      W_FRAME_HI, W_EVENT_HI, W_READ1_HI, W_READ2_HI: rsvd_err = (word[15:8] != 8'h00);
      W_HIST:  rsvd_err = (word[15:11] != 5'd0);
      W_TRAIL: rsvd_err = (word != 16'h0000);
      default: rsvd_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      widx_reg   <= 4'd0;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      widx_reg   <= widx_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  // Within one byte the checks are ordered header > flag > marker > reserved.
  always_comb begin
    state_next = state_reg;
    widx_next  = widx_reg;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    publish    = 1'b0;
    hdr_accept = 1'b0;
    crate_load = 1'b0;
    word_load  = 1'b0;
    if (byte_valid) begin
      if (state_reg == ST_IDLE) begin
        if (is_hdr) begin
          hdr_accept = 1'b1;
          state_next = ST_CRATE;
        end
      end else if (is_hdr) begin
        abort      = 1'b1;
        abort_code = ERR_RESYNC;
        hdr_accept = 1'b1;
        state_next = ST_CRATE;
      end else begin
        case (state_reg)
          ST_CRATE: begin
            if (bytin[9:8] != LO) begin
              abort = 1'b1; abort_code = ERR_FLAG;
            end else if (bytin[7:5] != 3'd0) begin
              abort = 1'b1; abort_code = ERR_RSVD;
            end else begin
              crate_load = 1'b1;
              widx_next  = W_MARK;
              state_next = ST_HI;
            end
          end
          ST_HI: begin
            if (flag_err) begin
              abort = 1'b1; abort_code = ERR_FLAG;
            end else begin
              state_next = ST_LO;
            end
          end
          ST_LO: begin
            if (flag_err) begin
              abort = 1'b1; abort_code = ERR_FLAG;
            end else if ((widx_reg == W_MARK) && (word != MARKER)) begin
              abort = 1'b1; abort_code = ERR_MARKER;
            end else if (rsvd_err) begin
              abort = 1'b1; abort_code = ERR_RSVD;
            end else if (word_strobe) begin
              word_load = 1'b1;
              if (grp_end && (widx_reg == W_TRAIL)) begin
                publish    = 1'b1;
                state_next = ST_IDLE;
              end else begin
                widx_next  = widx_reg + 4'd1;
                state_next = ST_HI;
              end
            end
          end
          default: state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
      end
    end else if (busy && (to_cnt_reg == TO_WIDTH'(TIMEOUT - 1))) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
      state_next = ST_IDLE;
    end

    if (byte_valid || !busy || abort) to_cnt_next = '0;
    else                             to_cnt_next = to_cnt_reg + TO_WIDTH'(1);
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      sh_crate_reg <= '0;
      sh_frame_reg <= '0; sh_event_reg <= '0; sh_read1_reg <= '0; sh_read2_reg <= '0;
      sh_t1c_reg   <= '0; sh_t1d_reg   <= '0; sh_t2c_reg   <= '0; sh_t2d_reg   <= '0;
      sh_hist_reg  <= '0;
    end else if (hdr_accept) begin
      sh_crate_reg <= '0;
      sh_frame_reg <= '0; sh_event_reg <= '0; sh_read1_reg <= '0; sh_read2_reg <= '0;
      sh_t1c_reg   <= '0; sh_t1d_reg   <= '0; sh_t2c_reg   <= '0; sh_t2d_reg   <= '0;
      sh_hist_reg  <= '0;
    end else if (crate_load) begin
      sh_crate_reg <= bytin[4:0];
    end else if (word_load) begin
      case (widx_reg)
        W_FRAME_LO: sh_frame_reg[15:0]  <= word;
        W_FRAME_HI: sh_frame_reg[23:16] <= word[7:0];
        W_EVENT_LO: sh_event_reg[15:0]  <= word;
        W_EVENT_HI: sh_event_reg[23:16] <= word[7:0];
        W_READ1_LO: sh_read1_reg[15:0]  <= word;
        W_READ1_HI: sh_read1_reg[23:16] <= word[7:0];
        W_READ2_LO: sh_read2_reg[15:0]  <= word;
        W_READ2_HI: sh_read2_reg[23:16] <= word[7:0];
        W_ERR1:     {sh_t1d_reg, sh_t1c_reg} <= word;
        W_ERR2:     {sh_t2d_reg, sh_t2c_reg} <= word;
        W_HIST:     sh_hist_reg <= word[10:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      crate        <= '0;
      framecount   <= '0; eventcount   <= '0; read1count   <= '0; read2count   <= '0;
      t1_err_c_cnt <= '0; t1_err_d_cnt <= '0; t2_err_c_cnt <= '0; t2_err_d_cnt <= '0;
      hist_wcount  <= '0;
      rec_valid    <= 1'b0;
      rec_err      <= 1'b0;
      err_code     <= '0;
      rec_count    <= '0;
      err_count    <= '0;
    end else begin
      rec_valid <= publish;
      rec_err   <= abort;
      if (abort) begin
        err_code <= abort_code;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (publish) begin
        crate        <= sh_crate_reg;
        framecount   <= sh_frame_reg;
        eventcount   <= sh_event_reg;
        read1count   <= sh_read1_reg;
        read2count   <= sh_read2_reg;
        t1_err_c_cnt <= sh_t1c_reg;
        t1_err_d_cnt <= sh_t1d_reg;
        t2_err_c_cnt <= sh_t2c_reg;
        t2_err_d_cnt <= sh_t2d_reg;
        hist_wcount  <= sh_hist_reg;
        rec_count    <= rec_count + 16'd1;
      end
    end
  end

endmodule
